// File: rtl/mor1kx_cfgrs_spr_slave.sv
// SPR-bus responder for the group-0 configuration/version register window.
// Optional build macro MOR1KX_CFGRS_WRITE_ERR_EN: flag in-window writes on spr_bus_err_o.
module mor1kx_cfgrs_spr_slave #(
  parameter int OPTION_READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] spr_bus_addr_i,
  input  logic        spr_bus_we_i,
  input  logic        spr_bus_stb_i,
  input  logic [31:0] spr_bus_dat_i,
  input  logic [31:0] spr_vr,
  input  logic [31:0] spr_upr,
  input  logic [31:0] spr_cpucfgr,
  input  logic [31:0] spr_dmmucfgr,
  input  logic [31:0] spr_immucfgr,
  input  logic [31:0] spr_dccfgr,
  input  logic [31:0] spr_iccfgr,
  input  logic [31:0] spr_dcfgr,
  input  logic [31:0] spr_pccfgr,
  input  logic [31:0] spr_vr2,
  input  logic [31:0] spr_avr,
  output logic        spr_bus_ack_o,
  output logic [31:0] spr_bus_dat_o,
  output logic        spr_bus_err_o
);

  // Out-of-range latency settings fall back to single-cycle response.
  localparam int LAT = (OPTION_READ_LATENCY >= 1 && OPTION_READ_LATENCY <= 4) ?
                       OPTION_READ_LATENCY : 1;
  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_RELEASE
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [3:0]  idx_reg, idx_next;
  logic        we_reg, we_next;
  logic        ack_reg, ack_next;
  logic [31:0] dat_reg, dat_next;

  logic        in_window;
  logic        resp_load;
  logic [3:0]  resp_idx;
  logic        resp_we;
  logic [31:0] resp_word;

  // Write data is never stored; this register window is read-only.
  logic unused_dat;
  assign unused_dat = &{1'b0, spr_bus_dat_i};

  assign in_window = (spr_bus_addr_i[15:4] == 12'h000);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    we_next    = we_reg;
    resp_load  = 1'b0;
    resp_idx   = idx_reg;
    resp_we    = we_reg;
    case (state_reg)
      S_IDLE: begin
        if (spr_bus_stb_i && in_window) begin
          idx_next = spr_bus_addr_i[3:0];
          we_next  = spr_bus_we_i;
          cnt_next = CNT_INIT;
          if (LAT > 1) begin
            state_next = S_WAIT;
          end else begin
            // No latched copy exists yet, so respond straight from the bus.
            state_next = S_RESP;
            resp_load  = 1'b1;
            resp_idx   = spr_bus_addr_i[3:0];
            resp_we    = spr_bus_we_i;
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 2'd1;
        if (cnt_reg == 2'd1) begin
          state_next = S_RESP;
          resp_load  = 1'b1;
        end
      end
      S_RESP: begin
        state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!spr_bus_stb_i) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    resp_word = 32'h0;
    case (resp_idx)
      4'd0:    resp_word = spr_vr;
      4'd1:    resp_word = spr_upr;
      4'd2:    resp_word = spr_cpucfgr;
      4'd3:    resp_word = spr_dmmucfgr;
      4'd4:    resp_word = spr_immucfgr;
      4'd5:    resp_word = spr_dccfgr;
      4'd6:    resp_word = spr_iccfgr;
      4'd7:    resp_word = spr_dcfgr;
      4'd8:    resp_word = spr_pccfgr;
      4'd9:    resp_word = spr_vr2;
      4'd10:   resp_word = spr_avr;
      default: resp_word = 32'h0;
    endcase
  end

  // Outputs are registered and only non-zero in the single RESP cycle.
  always_comb begin
    ack_next = resp_load;
    dat_next = (resp_load && !resp_we) ? resp_word : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 2'd0;
      idx_reg   <= 4'd0;
      we_reg    <= 1'b0;
      ack_reg   <= 1'b0;
      dat_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      we_reg    <= we_next;
      ack_reg   <= ack_next;
      dat_reg   <= dat_next;
    end
  end

  assign spr_bus_ack_o = ack_reg;
  assign spr_bus_dat_o = dat_reg;

`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
  logic err_reg, err_next;

  assign err_next = resp_load && resp_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign spr_bus_err_o = err_reg;
`else
  assign spr_bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_slave.sv
// Self-checking bench: four responders (latency 1, 3, 4 and illegal 7) share one SPR bus.
module tb_mor1kx_cfgrs_spr_slave;

  localparam int NI = 4;
  localparam int LATS [NI] = '{1, 3, 4, 7};
`ifdef MOR1KX_CFGRS_WRITE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        we;
  logic        stb;
  logic [31:0] dat_i;
  logic [31:0] cfg [11];
  logic        ack_w [NI];
  logic [31:0] dat_w [NI];
  logic        err_w [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      mor1kx_cfgrs_spr_slave #(.OPTION_READ_LATENCY(LATS[gi])) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spr_bus_addr_i(addr),
        .spr_bus_we_i  (we),
        .spr_bus_stb_i (stb),
        .spr_bus_dat_i (dat_i),
        .spr_vr        (cfg[0]),
        .spr_upr       (cfg[1]),
        .spr_cpucfgr   (cfg[2]),
        .spr_dmmucfgr  (cfg[3]),
        .spr_immucfgr  (cfg[4]),
        .spr_dccfgr    (cfg[5]),
        .spr_iccfgr    (cfg[6]),
        .spr_dcfgr     (cfg[7]),
        .spr_pccfgr    (cfg[8]),
        .spr_vr2       (cfg[9]),
        .spr_avr       (cfg[10]),
        .spr_bus_ack_o (ack_w[gi]),
        .spr_bus_dat_o (dat_w[gi]),
        .spr_bus_err_o (err_w[gi])
      );
    end
  endgenerate

  function automatic int eff_lat(input int l);
    return (l >= 1 && l <= 4) ? l : 1;
  endfunction

  function automatic logic [31:0] ref_word(input logic [3:0] idx);
    return (idx <= 4'd10) ? cfg[idx] : 32'h0;
  endfunction

  task automatic chk(input string tag, input int inst, input int t,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d cycle=%0d observed=%h expected=%h", tag, inst, t, obs, exp);
    end
  endtask

  task automatic chk_outputs(input int t, input bit any_ack, input logic [31:0] word,
                             input logic w);
    for (int i = 0; i < NI; i++) begin
      bit exp_ack = any_ack && (t == eff_lat(LATS[i]));
      chk("ack", i, t, 32'(ack_w[i]), 32'(exp_ack));
      chk("dat", i, t, dat_w[i], exp_ack ? word : 32'h0);
      chk("err", i, t, 32'(err_w[i]), 32'(exp_ack && w && ERR_EN));
    end
  endtask

  // One access starting in an idle cycle; stb held for 'hold' cycles, then
  // enough idle cycles for every instance to return to IDLE.
  task automatic access(input logic [15:0] a, input logic w, input int hold,
                        input bit scramble);
    bit          inwin = (a[15:4] == 12'h000);
    logic [31:0] word  = w ? 32'h0 : ref_word(a[3:0]);
    int          tn    = ((hold > 5) ? hold : 5) + 1;
    for (int t = 0; t < tn; t++) begin
      @(posedge clk);
      #1;
      stb = (t < hold);
      if (t == 0) begin
        addr  = a;
        we    = w;
        dat_i = $urandom;
      end else if (scramble && inwin) begin
        addr = 16'($urandom);
        we   = 1'($urandom);
      end
      @(negedge clk);
      chk_outputs(t, inwin, word, w);
    end
    $display("access addr=%h we=%0d hold=%0d inwin=%0d word=%h", a, w, hold, inwin, word);
  endtask

  initial begin
    rst_n = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    addr  = 16'h0;
    dat_i = 32'h0;
    for (int i = 0; i < 11; i++) cfg[i] = $urandom;
    cfg[9]  = 32'h0105_0001;
    cfg[10] = 32'h0101_0000;

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_ack", i, 0, 32'(ack_w[i]), 32'h0);
      chk("rst_dat", i, 0, dat_w[i], 32'h0);
      chk("rst_err", i, 0, 32'(err_w[i]), 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    access(16'h0009, 1'b0, 6, 1'b0);   // VR2
    access(16'h000A, 1'b0, 6, 1'b1);   // AVR with address churn after accept
    access(16'h0002, 1'b0, 8, 1'b0);   // long strobe: exactly one ack
    access(16'h0002, 1'b0, 6, 1'b0);   // re-assert after one low cycle
    access(16'h000D, 1'b0, 6, 1'b0);   // unmapped index reads zero
    access(16'h0800, 1'b0, 10, 1'b0);  // group 1: ignored
    access(16'h0010, 1'b0, 6, 1'b0);   // index 16: outside window
    access(16'h0001, 1'b1, 6, 1'b0);   // write UPR
    access(16'h0001, 1'b0, 6, 1'b0);   // UPR unchanged
    access(16'h0000, 1'b0, 1, 1'b0);   // master abort after one cycle
    access(16'h000F, 1'b1, 2, 1'b1);

    // Reset in cycle 2 of a read: outputs clear immediately, no late ack.
    for (int t = 0; t < 2; t++) begin
      @(posedge clk);
      #1;
      stb  = 1'b1;
      addr = 16'h0003;
      we   = 1'b0;
      @(negedge clk);
      chk_outputs(t, 1'b1, cfg[3], 1'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("mid_rst_ack", i, 2, 32'(ack_w[i]), 32'h0);
      chk("mid_rst_dat", i, 2, dat_w[i], 32'h0);
      chk("mid_rst_err", i, 2, 32'(err_w[i]), 32'h0);
    end
    @(posedge clk);
    #1 stb = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk_outputs(100, 1'b0, 32'h0, 1'b0);
    end
    $display("reset mid-access done");
    access(16'h0004, 1'b0, 6, 1'b0);

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      logic        w;
      int          h;
      if ($urandom_range(9, 0) < 7) a = {12'h000, 4'($urandom)};
      else                          a = 16'($urandom) | 16'h0010;
      w = ($urandom_range(3, 0) == 0);
      h = $urandom_range(8, 1);
      access(a, w, h, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
